// File: rtl/bp_pkg.sv
// Shared entry type and counter helpers for the set-associative branch target buffer.
package bp_pkg;

  localparam int unsigned XLEN_MAX  = 64;
  localparam int unsigned CNT_MAX_W = 4;

  // Fields are sized for the widest legal configuration; unused upper bits stay zero.
  typedef struct packed {
    logic                 valid;
    logic [XLEN_MAX-1:0]  tag;
    logic [XLEN_MAX-1:0]  target;
    logic [CNT_MAX_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned w);
    return CNT_MAX_W'((1 << w) - 1);
  endfunction

  function automatic logic [CNT_MAX_W-1:0] cnt_init(input int unsigned w);
    return CNT_MAX_W'(1 << (w - 1));
  endfunction

endpackage

// File: rtl/btb_victim.sv
// Victim way choice and next replacement state for one BTB set.
// BTB_PLRU_EN selects tree pseudo-LRU; otherwise a round-robin pointer is used.
module btb_victim #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned WL2    = $clog2(WAYS),
  parameter int unsigned REPL_W = WL2
) (
  input  logic [WAYS-1:0]   i_valid,
  input  logic [REPL_W-1:0] i_repl,
  input  logic [WL2-1:0]    i_touch_way,
  input  logic              i_touch_victim,
  output logic [WL2-1:0]    o_victim,
  output logic [REPL_W-1:0] o_repl_next
);

  logic [WL2-1:0] w_repl_way;

`ifdef BTB_PLRU_EN
  logic w_unused_touch;
  assign w_unused_touch = i_touch_victim;

  // Heap-ordered tree: node n lives in bit n-1, a set bit steers toward the upper half.
  always_comb begin
    logic [WL2:0] node;
    node = (WL2+1)'(1);
    for (int l = 0; l < int'(WL2); l++) begin
      node = {node[WL2-1:0], i_repl[WL2'(node - 1'b1)]};
    end
    w_repl_way = node[WL2-1:0];
  end

  always_comb begin
    logic [WL2:0] node;
    o_repl_next = i_repl;
    node        = (WL2+1)'(1);
    for (int l = 0; l < int'(WL2); l++) begin
      o_repl_next[WL2'(node - 1'b1)] = ~i_touch_way[WL2'(int'(WL2) - 1 - l)];
      node = {node[WL2-1:0], i_touch_way[WL2'(int'(WL2) - 1 - l)]};
    end
  end
`else
  assign w_repl_way = i_repl;

  // Pointer only moves past a way that was actually evicted.
  always_comb begin
    o_repl_next = i_repl;
    if (i_touch_victim) begin
      o_repl_next = REPL_W'(i_touch_way + 1'b1);
    end
  end
`endif

  // Lowest invalid way wins over the replacement choice.
  always_comb begin
    o_victim = w_repl_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim = WL2'(w);
      end
    end
  end

endmodule

// File: rtl/btb_sa.sv
// Set-associative branch target buffer with zero-latency lookup and saturating direction counters.
// Define BTB_PLRU_EN for tree pseudo-LRU replacement; default is round-robin.
module btb_sa
  import bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SETS_LOG2 = 6,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  output logic            hit,
  output logic            taken,
  output logic [XLEN-1:0] paddr,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush
);

  localparam int unsigned SETS = 1 << SETS_LOG2;
  localparam int unsigned WL2  = $clog2(WAYS);
`ifdef BTB_PLRU_EN
  localparam int unsigned REPL_W = WAYS - 1;
`else
  localparam int unsigned REPL_W = WL2;
`endif
  localparam logic [CNT_MAX_W-1:0] CNT_TOP  = cnt_max(CNT_W);
  localparam logic [CNT_MAX_W-1:0] CNT_INIT = cnt_init(CNT_W);

  btb_entry_t        r_tab  [SETS][WAYS];
  logic [REPL_W-1:0] r_repl [SETS];

  logic [SETS_LOG2-1:0] w_lset, w_uset;
  logic [XLEN_MAX-1:0]  w_ltag, w_utag;
  logic                 w_unused_lsb;

  assign w_lset       = addr[SETS_LOG2+1:2];
  assign w_ltag       = XLEN_MAX'(addr[XLEN-1:SETS_LOG2+2]);
  assign w_uset       = upd_pc[SETS_LOG2+1:2];
  assign w_utag       = XLEN_MAX'(upd_pc[XLEN-1:SETS_LOG2+2]);
  assign w_unused_lsb = ^{addr[1:0], upd_pc[1:0]};

  // Fetch-side lookup; descending scan leaves the lowest matching way in place.
  always_comb begin
    btb_entry_t e;
    e     = '0;
    hit   = 1'b0;
    taken = 1'b0;
    paddr = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      e = r_tab[w_lset][w];
      if (e.valid && e.tag == w_ltag) begin
        hit   = 1'b1;
        taken = e.cnt[CNT_W-1];
        paddr = XLEN'(e.target);
      end
    end
  end

  logic            w_uhit;
  logic [WL2-1:0]  w_uway;
  logic [WAYS-1:0] w_uvalid;

  always_comb begin
    w_uhit   = 1'b0;
    w_uway   = '0;
    w_uvalid = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_uvalid[w] = r_tab[w_uset][w].valid;
      if (r_tab[w_uset][w].valid && r_tab[w_uset][w].tag == w_utag) begin
        w_uhit = 1'b1;
        w_uway = WL2'(w);
      end
    end
  end

  logic [WL2-1:0]    w_victim, w_touch_way;
  logic              w_touch_victim;
  logic [REPL_W-1:0] w_repl_next;

  assign w_touch_way    = w_uhit ? w_uway : w_victim;
  assign w_touch_victim = !w_uhit && (&w_uvalid);

  btb_victim #(
    .WAYS   (WAYS),
    .WL2    (WL2),
    .REPL_W (REPL_W)
  ) u_victim (
    .i_valid        (w_uvalid),
    .i_repl         (r_repl[w_uset]),
    .i_touch_way    (w_touch_way),
    .i_touch_victim (w_touch_victim),
    .o_victim       (w_victim),
    .o_repl_next    (w_repl_next)
  );

  logic [CNT_MAX_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_tab[w_uset][w_uway].cnt;
    if (upd_taken) begin
      if (w_cnt_next != CNT_TOP) w_cnt_next = w_cnt_next + 1'b1;
    end else if (w_cnt_next != '0) begin
      w_cnt_next = w_cnt_next - 1'b1;
    end
  end

  // Table update: flush beats update, at most one entry written per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) r_tab[s][w] <= '0;
        r_repl[s] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) r_tab[s][w].valid <= 1'b0;
        r_repl[s] <= '0;
      end
    end else if (upd_valid) begin
      if (w_uhit) begin
        r_tab[w_uset][w_uway].cnt <= w_cnt_next;
        if (upd_taken) r_tab[w_uset][w_uway].target <= XLEN_MAX'(upd_target);
        r_repl[w_uset] <= w_repl_next;
      end else if (upd_taken) begin
        r_tab[w_uset][w_victim] <= '{valid:  1'b1,
                                     tag:    w_utag,
                                     target: XLEN_MAX'(upd_target),
                                     cnt:    CNT_INIT};
        r_repl[w_uset] <= w_repl_next;
      end
    end
  end

endmodule

// File: tb/tb_btb_sa.sv
// Bench for btb_sa: directed scenarios then random traffic checked against a behavioural model.
module tb_btb_sa;

  localparam int XLEN      = 32;
  localparam int SETS_LOG2 = 6;
  localparam int WAYS      = 4;
  localparam int CNT_W     = 2;
  localparam int SETS      = 1 << SETS_LOG2;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int CHALF     = 1 << (CNT_W - 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] addr, paddr, upd_pc, upd_target;
  logic            hit, taken, upd_valid, upd_taken, flush;

  btb_sa #(.XLEN(XLEN), .SETS_LOG2(SETS_LOG2), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .hit        (hit),
    .taken      (taken),
    .paddr      (paddr),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per-set list of entries plus replacement bookkeeping.
  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          cnt;
  } ment_t;

  ment_t         m      [SETS][WAYS];
  int            m_rr   [SETS];
  bit [WAYS-2:0] m_tree [SETS];

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc >> 2) & (SETS - 1));
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] pc);
    return pc >> (SETS_LOG2 + 2);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = m_set(pc);
    for (int w = 0; w < WAYS; w++)
      if (m[s][w].v && m[s][w].tag == m_tag(pc)) return w;
    return -1;
  endfunction

  task automatic m_clear(input bit all);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m[s][w].v = 1'b0;
        if (all) m[s][w] = '{v: 1'b0, tag: 0, tgt: '0, cnt: 0};
      end
      m_rr[s]   = 0;
      m_tree[s] = '0;
    end
  endtask

  function automatic int m_repl_way(input int s);
`ifdef BTB_PLRU_EN
    int n = 1;
    while (n < WAYS) n = 2 * n + int'(m_tree[s][n-1]);
    return n - WAYS;
`else
    return m_rr[s];
`endif
  endfunction

  task automatic m_touch(input int s, input int w, input bit replaced);
`ifdef BTB_PLRU_EN
    int n = 1;
    for (int l = $clog2(WAYS) - 1; l >= 0; l--) begin
      int d = (w >> l) & 1;
      m_tree[s][n-1] = (d == 0);
      n = 2 * n + d;
    end
`else
    if (replaced) m_rr[s] = (m_rr[s] + 1) % WAYS;
`endif
  endtask

  task automatic m_update(input bit fl, input bit uv, input logic [31:0] pc,
                          input logic [31:0] tgt, input bit tk);
    int s, w, vic;
    bit replaced;
    if (fl) begin
      m_clear(1'b0);
      return;
    end
    if (!uv) return;
    s = m_set(pc);
    w = m_find(pc);
    if (w >= 0) begin
      m[s][w].cnt = tk ? ((m[s][w].cnt < CMAX) ? m[s][w].cnt + 1 : CMAX)
                       : ((m[s][w].cnt > 0) ? m[s][w].cnt - 1 : 0);
      if (tk) m[s][w].tgt = tgt;
      m_touch(s, w, 1'b0);
    end else if (tk) begin
      vic = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!m[s][i].v) vic = i;
      replaced = (vic < 0);
      if (replaced) vic = m_repl_way(s);
      m[s][vic] = '{v: 1'b1, tag: m_tag(pc), tgt: tgt, cnt: CHALF};
      m_touch(s, vic, replaced);
    end
  endtask

  logic        o_hit, o_tk;
  logic [31:0] o_pa;

  // One cycle: drive mid-cycle, check lookup against pre-edge model, then advance model.
  task automatic step(input logic [31:0] a, input bit uv, input logic [31:0] upc,
                      input logic [31:0] utgt, input bit utk, input bit fl);
    int w;
    @(negedge clk);
    addr = a; upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk; flush = fl;
    #1;
    o_hit = hit; o_tk = taken; o_pa = paddr;
    w = m_find(a);
    chk("model_hit", 32'(o_hit), 32'(w >= 0));
    chk("model_taken", 32'(o_tk), 32'((w >= 0) && (m[m_set(a)][w].cnt >= CHALF)));
    chk("model_paddr", o_pa, (w >= 0) ? m[m_set(a)][w].tgt : 32'h0);
    @(posedge clk);
    m_update(fl, uv, upc, utgt, utk);
  endtask

  task automatic look(input logic [31:0] a);
    step(a, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    step(pc, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    addr = 32'h1000; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; flush = 1'b0;
    m_clear(1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_taken", 32'(taken), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    @(negedge clk) rst = 1'b1;

    look(32'h1000);
    chk("cold_hit", 32'(o_hit), 32'h0);

    upd(32'h1000, 32'h2000, 1'b1);
    look(32'h1000);
    chk("alloc_hit", 32'(o_hit), 32'h1);
    chk("alloc_taken", 32'(o_tk), 32'h1);
    chk("alloc_paddr", o_pa, 32'h2000);

    // Same-cycle lookup shows pre-update counter.
    upd(32'h1000, 32'h5555, 1'b0);
    chk("bypass_old_taken", 32'(o_tk), 32'h1);
    look(32'h1000);
    chk("nt1_taken", 32'(o_tk), 32'h0);
    chk("nt1_hit", 32'(o_hit), 32'h1);
    chk("nt1_paddr", o_pa, 32'h2000);
    upd(32'h1000, 32'h0, 1'b0);
    upd(32'h1000, 32'h0, 1'b0);
    upd(32'h1000, 32'h2400, 1'b1);
    look(32'h1000);
    chk("sat_low_taken", 32'(o_tk), 32'h0);
    chk("sat_low_paddr", o_pa, 32'h2400);
    repeat (3) upd(32'h1000, 32'h2400, 1'b1);
    upd(32'h1000, 32'h2400, 1'b0);
    look(32'h1000);
    chk("sat_high_taken", 32'(o_tk), 32'h1);

    step(32'h1000, 1'b1, 32'h3000, 32'h3100, 1'b1, 1'b1);
    look(32'h3000);
    chk("flush_drop_hit", 32'(o_hit), 32'h0);
    look(32'h1000);
    chk("flush_clear_hit", 32'(o_hit), 32'h0);

    for (int k = 0; k < 5; k++) upd(32'h1000 + 32'(k) * 32'h100, 32'h8000 + 32'(k), 1'b1);
    look(32'h1000);
    chk("evict0_hit", 32'(o_hit), 32'h0);
    look(32'h1400);
    chk("fifth_paddr", o_pa, 32'h8004);
    upd(32'h1300, 32'h8003, 1'b1);
    upd(32'h1500, 32'h8005, 1'b1);
    look(32'h1100);
    chk("evict1_hit", 32'(o_hit), 32'h0);
    look(32'h1300);
    chk("keep3_hit", 32'(o_hit), 32'h1);

    // Reset arriving while an update is presented discards it.
    @(negedge clk);
    addr = 32'h1600; upd_valid = 1'b1; upd_pc = 32'h1600; upd_target = 32'h9000; upd_taken = 1'b1;
    #2 rst = 1'b0;
    #1 chk("async_rst_hit", 32'(hit), 32'h0);
    addr = 32'h1400;
    #1 chk("async_rst_hit2", 32'(hit), 32'h0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b1;
    m_clear(1'b1);
    look(32'h1600);
    chk("rst_mid_upd_hit", 32'(o_hit), 32'h0);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      pc = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pc = $urandom;
      a = ($urandom_range(0, 1) == 0) ? pc
        : ((32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 2)) << 2));
      step(a, $urandom_range(0, 9) < 6, pc, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btb_sa.md
BTB_SA -- requirements
Module: btb_sa

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width in bits.
REQ-002 SHALL have parameter SETS_LOG2, default 6, log2 of set count (64 sets).
REQ-003 SHALL have parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-004 SHALL have parameter CNT_W, default 2, saturating-counter width; 2..4.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port addr  input  XLEN  fetch PC for lookup.
REQ-008 SHALL have port hit  output  1  addr matches a valid entry.
REQ-009 SHALL have port taken  output  1  hit and counter MSB set.
REQ-010 SHALL have port paddr  output  XLEN  predicted target of hitting entry; 0 on miss.
REQ-011 SHALL have port upd_valid  input  1  resolved branch update strobe.
REQ-012 SHALL have port upd_pc  input  XLEN  PC of resolved branch.
REQ-013 SHALL have port upd_target  input  XLEN  resolved target.
REQ-014 SHALL have port upd_taken  input  1  resolved direction.
REQ-015 SHALL have port flush  input  1  synchronous invalidate-all.

Function
REQ-016 SHALL derive set index = pc[SETS_LOG2+1:2] and tag = pc[XLEN-1:SETS_LOG2+2] for both lookup and update.
REQ-017 SHALL produce hit/taken/paddr combinationally from addr in the same cycle (zero latency) from current-state table contents.
REQ-018 SHALL report the lowest-numbered matching way if multiple ways match (not expected in normal operation).
REQ-019 On upd_valid and hit in set: counter SHALL increment if upd_taken, decrement otherwise, saturating at 2^CNT_W-1 and 0.
REQ-020 On upd_valid, hit and upd_taken: stored target SHALL be overwritten with upd_target; not-taken SHALL leave target unchanged.
REQ-021 On upd_valid, miss and upd_taken: SHALL allocate a way in the set: lowest-numbered invalid way first, else the replacement victim (REQ-031/032); entry gets tag, upd_target, valid=1, counter=2^(CNT_W-1) (weakly taken).
REQ-022 On upd_valid, miss and not upd_taken: no allocation, no state change.
REQ-023 Replacement state of a set SHALL be touched only on an update hit or allocation in that set, never on lookup.
REQ-024 Lookup and update to the same entry in one cycle: lookup SHALL return pre-update values.
REQ-025 flush SHALL clear all valid bits and replacement state on the next edge; flush wins over a simultaneous upd_valid (update dropped).
REQ-026 At most one entry SHALL be written per cycle.

Reset
REQ-027 While rst=0, all valid bits, counters, tags, targets and replacement state SHALL be 0, asynchronously.
REQ-028 During and after reset, outputs SHALL be hit=0, taken=0, paddr=0 until an allocation occurs.
REQ-029 Reset asserted mid-update SHALL discard that update.
REQ-030 State SHALL begin updating on the first rising clk edge after rst deasserts.

Configuration
REQ-031 With BTB_PLRU_EN defined: victim SHALL be chosen by per-set tree pseudo-LRU (WAYS-1 bits), each touch pointing tree bits away from the touched way.
REQ-032 Without BTB_PLRU_EN: victim SHALL be a per-set log2(WAYS)-bit round-robin pointer, advancing by 1 (wrapping) only when a victim (not an invalid way) is replaced; hits do not move it.

Structure
REQ-033 Package bp_pkg SHALL hold the entry struct typedef (valid, tag, target, counter) and the counter-init and saturation helper constants.
REQ-034 Victim selection (both schemes under the macro) SHALL be a sub-module named btb_victim: inputs set valid vector, replacement state, touch way; outputs victim way and next replacement state.

Verification
REQ-035 Reset then addr=0x0000_1000 -> hit=0, taken=0, paddr=0.
REQ-036 upd_valid, upd_pc=0x1000, upd_taken=1, upd_target=0x2000; next cycle addr=0x1000 -> hit=1, taken=1, paddr=0x2000 (counter=2).
REQ-037 Two not-taken updates to 0x1000 -> counter 2->1->0, taken=0, hit=1; third not-taken keeps counter 0.
REQ-038 WAYS=4: five taken allocations to PCs 0x1000+k*0x100 (same set 0) -> fifth evicts way 0 (round-robin) or the PLRU way; evicted PC lookup gives hit=0.
REQ-039 flush and upd_valid same cycle -> all lookups miss afterward; update not present.
REQ-040 Update hit to 0x1000 with lookup of 0x1000 in same cycle -> outputs show old counter/target; next cycle shows new.
